muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit. Sits between the register file read ports and its write port.
- Consumes rs1/rs2 operand data plus the funct3 opcode from decode.
- Runs a 32-step shift-add multiply or restoring divide.
- Returns the result as a single-cycle write request (we/rd_addr/rd_data) that drives the register file write port.

---
 rtl/muldiv_unit.sv | 206 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
// muldiv_unit -- iterative RV32M multiply/divide unit.
//   Accepts one op (funct3 + rs1/rs2 + rd) while idle. Multiplies use a
//   32-step shift-add on operand magnitudes. Divides use a 32-step restoring
//   divide on magnitudes. The sign is applied to the final result.
//   The result leaves as a one-cycle register-file write request.
//   Divide-by-zero and signed overflow skip straight to the write cycle.
//   Optional macro MULDIV_FAST_MUL_EN: every MUL* op uses a single-cycle
//   33x33 signed multiply and also skips straight to the write cycle.
// Ports:
//   clk, rst_n            clock / async active-low reset
//   valid_i, ready_o      request handshake (ready_o = idle)
//   op_i                  funct3 (MUL..REMU)
//   rs1_data_i, rs2_data_i operands
//   rd_addr_i             destination register
//   flush_i               abort in-flight op, suppress pending write
//   busy_o                op in flight
//   we_o, rd_addr_o, rd_data_o  register-file write request
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            we_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o
);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                sign_q, sign_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;     // mul: {hi, multiplier}; div: {rem, quotient}
  logic [XLEN-1:0]     opb_q, opb_d;     // mul: multiplicand; div: divisor
  logic [4:0]          rd_pend_q, rd_pend_d;
  logic [4:0]          rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]     rd_data_q, rd_data_d;

  // ---- accept-side decode ----
  logic            a_signed, b_signed, res_sign;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf, div_special;
  logic [XLEN-1:0] spec_res;

  always_comb begin
    a_signed = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
               (op_i == OP_DIV) || (op_i == OP_REM);
    b_signed = (op_i == OP_MUL) || (op_i == OP_MULH) ||
               (op_i == OP_DIV) || (op_i == OP_REM);
    mag_a = (a_signed && rs1_data_i[XLEN-1]) ? -rs1_data_i : rs1_data_i;
    mag_b = (b_signed && rs2_data_i[XLEN-1]) ? -rs2_data_i : rs2_data_i;
    case (op_i)
      OP_MUL, OP_MULH, OP_DIV: res_sign = rs1_data_i[XLEN-1] ^ rs2_data_i[XLEN-1];
      OP_MULHSU, OP_REM:       res_sign = rs1_data_i[XLEN-1];
      default:                 res_sign = 1'b0;
    endcase
    div_zero    = (rs2_data_i == '0);
    div_ovf     = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                  (rs1_data_i == MIN_NEG) && (rs2_data_i == '1);
    div_special = op_i[2] && (div_zero || div_ovf);
    // op_i[1] selects remainder among the divide ops
    if (op_i[1]) spec_res = div_zero ? rs1_data_i : '0;
    else         spec_res = div_zero ? '1 : MIN_NEG;
  end

  // ---- optional single-cycle multiplier ----
  logic            fast_hit;
  logic [XLEN-1:0] fast_res;
`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fa, fb;
  logic signed [2*XLEN-1:0] fp;
  // 33-bit extension covers signed and unsigned operands in a single signed multiply
  assign fa       = {a_signed & rs1_data_i[XLEN-1], rs1_data_i};
  assign fb       = {b_signed & rs2_data_i[XLEN-1], rs2_data_i};
  assign fp       = (2*XLEN)'(fa) * (2*XLEN)'(fb);
  assign fast_hit = !op_i[2];
  assign fast_res = (op_i == OP_MUL) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
`else
  assign fast_hit = 1'b0;
  assign fast_res = '0;
`endif

  // ---- one iteration of shift-add multiply / restoring divide ----
  logic [XLEN:0]     mul_sum, div_tmp, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, iter, prod_s;
  logic [XLEN-1:0]   div_pick, div_s, calc_res;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    div_tmp  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_tmp - {1'b0, opb_q};
    // borrow out means the shifted remainder is below the divisor: restore
    div_next = div_diff[XLEN] ? {div_tmp[XLEN-1:0],  acc_q[XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    iter     = op_q[2] ? div_next : mul_next;
    prod_s   = sign_q ? -iter : iter;
    div_pick = op_q[1] ? iter[2*XLEN-1:XLEN] : iter[XLEN-1:0];
    div_s    = sign_q ? -div_pick : div_pick;
    if (op_q[2])              calc_res = div_s;
    else if (op_q == OP_MUL)  calc_res = prod_s[XLEN-1:0];
    else                      calc_res = prod_s[2*XLEN-1:XLEN];
  end

  // ---- next state ----
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    sign_d    = sign_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    rd_pend_d = rd_pend_q;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    case (state_q)
      IDLE: if (valid_i) begin
        if (div_special) begin
          state_d   = DONE;
          rd_addr_d = rd_addr_i;
          rd_data_d = spec_res;
        end else if (fast_hit) begin
          state_d   = DONE;
          rd_addr_d = rd_addr_i;
          rd_data_d = fast_res;
        end else begin
          state_d   = CALC;
          cnt_d     = CNT_W'(XLEN-1);
          op_d      = op_i;
          sign_d    = res_sign;
          rd_pend_d = rd_addr_i;
          acc_d     = {{XLEN{1'b0}}, op_i[2] ? mag_a : mag_b};
          opb_d     = op_i[2] ? mag_b : mag_a;
        end
      end
      CALC: begin
        acc_d = iter;
        if (cnt_q == '0) begin
          state_d   = DONE;
          rd_addr_d = rd_pend_q;
          rd_data_d = calc_res;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // flush beats everything, including a same-edge accept or completion
    if (flush_i) begin
      state_d   = IDLE;
      rd_addr_d = rd_addr_q;
      rd_data_d = rd_data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      sign_q    <= 1'b0;
      acc_q     <= '0;
      opb_q     <= '0;
      rd_pend_q <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      sign_q    <= sign_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      rd_pend_q <= rd_pend_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign ready_o   = (state_q == IDLE);
  assign busy_o    = (state_q != IDLE);
  // x0 writes are dropped; a flush in the DONE cycle kills the strobe directly
  assign we_o      = (state_q == DONE) && (rd_addr_q != '0) && !flush_i;
  assign rd_addr_o = rd_addr_q;
  assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
// Directed bench for muldiv_unit: arithmetic results, latency, special
// cases, flush and reset behaviour.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int ML = 0;
`else
  localparam int ML = 32;
`endif
  localparam int DL = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [2:0]  op_i = '0;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o;
  logic        we_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;

  int checks = 0;
  int failures = 0;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .rd_addr_i(rd_addr_i),
    .flush_i(flush_i), .busy_o(busy_o), .we_o(we_o), .rd_addr_o(rd_addr_o),
    .rd_data_o(rd_data_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait for the write strobe, check latency/result/hold.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    valid_i = 1'b1; op_i = op; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd;
    @(posedge clk); #1;
    valid_i = 1'b0; rs1_data_i = $urandom; rs2_data_i = $urandom;
    lat = 0;
    while (we_o !== 1'b1 && lat < 40) begin
      chk({tag, "_ready_low"}, {31'b0, ready_o}, 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_we"},   {31'b0, we_o}, 32'd1);
    chk({tag, "_lat"},  32'(lat), 32'(exp_lat));
    chk({tag, "_addr"}, {27'b0, rd_addr_o}, {27'b0, rd});
    chk({tag, "_data"}, rd_data_o, exp);
    @(posedge clk); #1;
    chk({tag, "_we_drop"}, {31'b0, we_o}, 32'd0);
    chk({tag, "_ready"},   {31'b0, ready_o}, 32'd1);
    chk({tag, "_hold"},    rd_data_o, exp);
  endtask

  initial begin
    int n;
    logic any_we;

    // reset state
    #12;
    chk("rst_ready", {31'b0, ready_o}, 32'd1);
    chk("rst_busy",  {31'b0, busy_o},  32'd0);
    chk("rst_we",    {31'b0, we_o},    32'd0);
    chk("rst_addr",  {27'b0, rd_addr_o}, 32'd0);
    chk("rst_data",  rd_data_o, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // multiply family
    run_op("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, ML);
    run_op("mulh",   3'd1, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, ML);
    run_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, ML);
    run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, ML);

    // divide family
    run_op("div",    3'd4, 32'hFFFFFFF9, 32'd2,   5'd9,  32'hFFFFFFFD, DL);
    run_op("rem",    3'd6, 32'hFFFFFFF9, 32'd2,   5'd10, 32'hFFFFFFFF, DL);
    run_op("divu",   3'd5, 32'd100,      32'd7,   5'd11, 32'd14,       DL);
    run_op("remu",   3'd7, 32'd100,      32'd7,   5'd12, 32'd2,        DL);

    // special cases
    run_op("div0",   3'd4, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 0);
    run_op("rem0",   3'd6, 32'd5,        32'd0,        5'd14, 32'd5,        0);
    run_op("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 0);
    run_op("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        0);

    // flush in the DONE cycle kills the strobe combinationally
    @(negedge clk);
    valid_i = 1'b1; op_i = 3'd5; rs1_data_i = 32'd9; rs2_data_i = 32'd0; rd_addr_i = 5'd17;
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk("done_flush_pre", {31'b0, we_o}, 32'd1);
    flush_i = 1'b1; #1;
    chk("done_flush_we", {31'b0, we_o}, 32'd0);
    @(posedge clk); #1; flush_i = 1'b0;
    chk("done_flush_ready", {31'b0, ready_o}, 32'd1);

    // flush mid-CALC
    @(negedge clk);
    valid_i = 1'b1; op_i = 3'd5; rs1_data_i = 32'd100; rs2_data_i = 32'd7; rd_addr_i = 5'd18;
    @(posedge clk); #1; valid_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush_i = 1'b1;
    @(posedge clk); #1; flush_i = 1'b0;
    chk("flush_ready", {31'b0, ready_o}, 32'd1);
    chk("flush_busy",  {31'b0, busy_o},  32'd0);
    any_we = 1'b0;
    repeat (40) begin @(posedge clk); #1; any_we |= we_o; end
    chk("flush_no_we", {31'b0, any_we}, 32'd0);
    run_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 5'd19, 32'd12, ML);

    // flush coincident with accept: nothing starts
    @(negedge clk);
    valid_i = 1'b1; flush_i = 1'b1; op_i = 3'd5; rs1_data_i = 32'd50; rs2_data_i = 32'd3; rd_addr_i = 5'd20;
    @(posedge clk); #1; valid_i = 1'b0; flush_i = 1'b0;
    chk("flush_acc_ready", {31'b0, ready_o}, 32'd1);
    chk("flush_acc_busy",  {31'b0, busy_o},  32'd0);

    // rd=0: runs full length, never writes
    @(negedge clk);
    valid_i = 1'b1; op_i = 3'd5; rs1_data_i = 32'd100; rs2_data_i = 32'd7; rd_addr_i = 5'd0;
    @(posedge clk); #1; valid_i = 1'b0;
    n = 0; any_we = 1'b0;
    while (busy_o === 1'b1 && n < 40) begin
      any_we |= we_o;
      @(posedge clk); #1; n++;
    end
    chk("rd0_busy_cycles", 32'(n), 32'd33);
    chk("rd0_no_we", {31'b0, any_we}, 32'd0);

    // reset mid-CALC
    @(negedge clk);
    valid_i = 1'b1; op_i = 3'd5; rs1_data_i = 32'd100; rs2_data_i = 32'd7; rd_addr_i = 5'd21;
    @(posedge clk); #1; valid_i = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("mrst_ready", {31'b0, ready_o}, 32'd1);
    chk("mrst_busy",  {31'b0, busy_o},  32'd0);
    chk("mrst_we",    {31'b0, we_o},    32'd0);
    chk("mrst_addr",  {27'b0, rd_addr_o}, 32'd0);
    chk("mrst_data",  rd_data_o, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    any_we = 1'b0;
    repeat (40) begin @(posedge clk); #1; any_we |= we_o; end
    chk("mrst_no_we", {31'b0, any_we}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
